encoder4_stream: RTL and testbench

Registered 4-to-2 encoder with a valid/ready stream interface: the inverse of the team's 2-to-4 decoder. It accepts a 4-bit one-hot word `d[0:3]` and returns the 2-bit index `{x,y}` that would regenerate that word through the decoder. It also flags zero-hot and multi-hot words and counts those errors. A two-entry output buffer lets the producer keep streaming while the consumer stalls.

---
 rtl/encoder4_stream.sv | 125 ++++++++++++
 tb/tb_encoder4_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/encoder4_stream.sv
// encoder4_stream: registered priority 4-to-2 encoder behind a two-entry
// valid/ready output buffer, with zero-hot / multi-hot flags and a
// saturating error counter.
module encoder4_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [0:3]       d,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
  output logic             y,
  output logic             none,
  output logic             multi,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic x;
    logic y;
    logic none;
    logic multi;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t enc;
  logic   accept;
  logic   pop;

  // Priority encode the incoming word; highest set index wins.
  always_comb begin
    enc       = '0;
    enc.none  = ~(d[0] | d[1] | d[2] | d[3]);
    enc.multi = (d[0] & d[1]) | (d[0] & d[2]) | (d[0] & d[3]) |
                (d[1] & d[2]) | (d[1] & d[3]) | (d[2] & d[3]);
    if (d[3])      {enc.x, enc.y} = 2'b11;
    else if (d[2]) {enc.x, enc.y} = 2'b10;
    else if (d[1]) {enc.x, enc.y} = 2'b01;
    else           {enc.x, enc.y} = 2'b00;
  end

  // Handshake flags come purely from the registered buffer state.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Buffer next-state and entry movement.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = enc;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = enc;                // new word replaces the departing head
        end else if (accept) begin
          tail_d  = enc;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Saturating error counter; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (accept && (enc.none || enc.multi) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // State, entries and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Head fields are masked so an empty buffer always reads zero.
  always_comb begin
    x       = out_valid & head_q.x;
    y       = out_valid & head_q.y;
    none    = out_valid & head_q.none;
    multi   = out_valid & head_q.multi;
    err_cnt = cnt_q;
  end

endmodule

// File: tb/tb_encoder4_stream.sv
// Bench for encoder4_stream: queue-based reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_encoder4_stream;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [0:3]       d = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             x, y, none, multi;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  encoder4_stream #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d(d), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y),
    .none(none), .multi(multi), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entry = {code[1:0], none, multi}
  logic [3:0] mq[$];
  int         mcnt = 0;
  bit         started = 0;

  function automatic logic [3:0] model_enc(input logic [0:3] w);
    int hi;
    int ones;
    logic [1:0] code;
    hi = -1;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (w[i]) begin
        hi = i;
        ones++;
      end
    end
    code = (hi < 0) ? 2'd0 : 2'(hi);
    return {code, (ones == 0), (ones >= 2)};
  endfunction

  always @(posedge clk) begin
    logic [3:0] e;
    bit acc, pp;
    if (rst) begin
      mq.delete();
      mcnt = 0;
      started = 1;
    end else if (started) begin
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && out_ready;
      e   = model_enc(d);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (err_clr) mcnt = 0;
      else if (acc && (e[1] || e[0]) && mcnt < CNT_MAX) mcnt++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] h;
    if (started && !rst) begin
      h = (mq.size() > 0) ? mq[0] : 4'h0;
      chk("model.out_valid", 8'(out_valid), 8'(mq.size() > 0));
      chk("model.in_ready", 8'(in_ready), 8'(mq.size() < 2));
      chk("model.head", 8'({x, y, none, multi}), 8'(h));
      chk("model.err_cnt", 8'(err_cnt), 8'(mcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [0:3] dd, input logic ordy);
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
  endtask

  // Literal check of head {x,y,none,multi} and err_cnt.
  task automatic lit(input string name, input logic [3:0] head, input int cnt);
    chk({name, ".head"}, 8'({x, y, none, multi}), 8'(head));
    chk({name, ".err"}, 8'(err_cnt), 8'(cnt));
  endtask

  initial begin
    logic [0:3] w;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset.out_valid", 8'(out_valid), 8'd0);
    chk("reset.in_ready", 8'(in_ready), 8'd1);
    lit("reset", 4'b0000, 0);

    // Back-to-back one-hot words
    drv(1, 4'b1000, 1); tick(); lit("oh0", 4'b0000, 0); chk("oh0.v", 8'(out_valid), 8'd1);
    drv(1, 4'b0100, 1); tick(); lit("oh1", 4'b0100, 0);
    drv(1, 4'b0010, 1); tick(); lit("oh2", 4'b1000, 0);
    drv(1, 4'b0001, 1); tick(); lit("oh3", 4'b1100, 0);
    drv(0, 4'b1111, 1); tick(); chk("oh.drain", 8'(out_valid), 8'd0);

    // Zero-hot and multi-hot
    drv(1, 4'b0000, 1); tick(); lit("zero", 4'b0010, 1);
    drv(1, 4'b0110, 1); tick(); lit("multi", 4'b1001, 2);
    drv(0, 4'b0000, 1); err_clr = 1; tick(); err_clr = 0;
    chk("clr", 8'(err_cnt), 8'd0);

    // Backpressure
    drv(1, 4'b0001, 0); tick(); chk("bp.rdy1", 8'(in_ready), 8'd1);
    drv(1, 4'b0010, 0); tick(); chk("bp.rdy2", 8'(in_ready), 8'd0);
    drv(1, 4'b0100, 0); tick(); lit("bp.hold", 4'b1100, 0);
    drv(1, 4'b0100, 1); tick(); lit("bp.pop1", 4'b1000, 0);
    tick(); lit("bp.pop2", 4'b0100, 0);
    drv(0, 4'b0000, 1); tick(); chk("bp.empty", 8'(out_valid), 8'd0);

    // Saturation at CNT_W=2
    drv(1, 4'b0000, 1); tick(); chk("sat1", 8'(err_cnt), 8'd1);
    tick(); chk("sat2", 8'(err_cnt), 8'd2);
    tick(); chk("sat3", 8'(err_cnt), 8'd3);
    tick(); chk("sat4", 8'(err_cnt), 8'd3);
    tick(); chk("sat5", 8'(err_cnt), 8'd3);
    err_clr = 1; tick(); err_clr = 0;
    chk("sat.clr", 8'(err_cnt), 8'd0);
    drv(0, 4'b0000, 1); tick();

    // Reset mid-stream with buffer full
    drv(1, 4'b0000, 0); tick();
    drv(1, 4'b0011, 0); tick();
    chk("mid.full", 8'(in_ready), 8'd0);
    chk("mid.err", 8'(err_cnt), 8'd2);
    drv(1, 4'b0000, 1); rst = 1; tick(); rst = 0;
    chk("mid.out_valid", 8'(out_valid), 8'd0);
    chk("mid.in_ready", 8'(in_ready), 8'd1);
    lit("mid", 4'b0000, 0);
    drv(1, 4'b0001, 1); tick(); lit("mid.after", 4'b1100, 0);
    drv(0, 4'b0000, 1); tick();

    // Steady state ONE with simultaneous accept and pop
    drv(1, 4'b1000, 0); tick();
    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(0, 3);
      w = 4'b1000 >> k;
      drv(1, w, 1); tick();
      chk("one.rdy", 8'(in_ready), 8'd1);
      chk("one.xy", 8'({x, y}), 8'(k));
      chk("one.flags", 8'({none, multi}), 8'd0);
    end
    drv(0, 4'b0000, 1); tick(); tick();
    chk("end.empty", 8'(out_valid), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
